// File: rtl/xform_sequencer.sv
// xform_sequencer: vertex-stage command sequencer driving the shared MAC and matrix-stack controls.
module xform_sequencer #(
   parameter int STACK_DEPTH = 4,
   parameter int SP_W = 2,
   parameter int OPCODE_WIDTH = 8,
   parameter logic [OPCODE_WIDTH-1:0] OP_BEGINPRIMITIVE = 8'h60,
   parameter logic [OPCODE_WIDTH-1:0] OP_ENDPRIMITIVE = 8'h61,
   parameter logic [OPCODE_WIDTH-1:0] OP_SETVERTEX = 8'h62,
   parameter logic [OPCODE_WIDTH-1:0] OP_ROTATE = 8'h63,
   parameter logic [OPCODE_WIDTH-1:0] OP_TRANSLATE = 8'h64,
   parameter logic [OPCODE_WIDTH-1:0] OP_SCALE = 8'h65,
   parameter logic [OPCODE_WIDTH-1:0] OP_PUSHMATRIX = 8'h66,
   parameter logic [OPCODE_WIDTH-1:0] OP_POPMATRIX = 8'h67,
   parameter logic [OPCODE_WIDTH-1:0] OP_LOADIDENTITY = 8'h68
) (
   input  logic                    I_CLOCK,
   input  logic                    I_RESET_N,
   input  logic                    I_LOCK,
   input  logic                    I_CMD_VALID,
   input  logic [OPCODE_WIDTH-1:0] I_Opcode,
   output logic                    O_CMD_READY,
   output logic                    O_MAC_EN,
   output logic                    O_MAC_CLR,
   output logic [SP_W-1:0]         O_A_SLOT,
   output logic [3:0]              O_A_IDX,
   output logic                    O_B_SRC,
   output logic [3:0]              O_B_IDX,
   output logic                    O_WR_EN,
   output logic [3:0]              O_WR_IDX,
   output logic                    O_COPY_EN,
   output logic                    O_COMMIT,
   output logic                    O_LOAD_ID,
   output logic                    O_VTX_VALID,
   output logic [SP_W-1:0]         O_SP,
   output logic                    O_PRIM_ACTIVE,
   output logic                    O_OVERFLOW,
   output logic                    O_UNDERFLOW
);
   typedef enum logic [2:0] {S_IDLE, S_EXEC1, S_SWEEP, S_WB, S_COMMIT, S_COPY, S_VDONE} state_t;
   localparam logic [SP_W-1:0] SP_MAX = SP_W'(STACK_DEPTH - 1);
   state_t state_q, state_d;
   logic vtx_q, vtx_d, prim_q, prim_d, ovf_q, ovf_d, unf_q, unf_d, ld_q, ld_d;
   logic [1:0] i_q, i_d, j_q, j_d, k_q, k_d;
   logic [3:0] n_q, n_d;
   logic [SP_W-1:0] sp_q, sp_d;
   logic mac_en, mac_clr, b_src, wr_en, copy_en, commit, load_id, vtx_valid;
   logic [SP_W-1:0] a_slot;
   logic [3:0] a_idx, b_idx, wr_idx;
   logic is_mat;
   assign is_mat = I_Opcode == OP_ROTATE || I_Opcode == OP_TRANSLATE || I_Opcode == OP_SCALE;
   always_comb begin
      state_d = state_q;
      vtx_d = vtx_q;
      prim_d = prim_q;
      ovf_d = ovf_q;
      unf_d = unf_q;
      ld_d = 1'b0;
      i_d = i_q;
      j_d = j_q;
      k_d = k_q;
      n_d = n_q;
      sp_d = sp_q;
      mac_en = 1'b0;
      mac_clr = 1'b0;
      a_slot = '0;
      a_idx = '0;
      b_src = 1'b0;
      b_idx = '0;
      wr_en = 1'b0;
      wr_idx = '0;
      copy_en = 1'b0;
      commit = 1'b0;
      load_id = 1'b0;
      vtx_valid = 1'b0;
      case (state_q)
         S_IDLE: if (I_CMD_VALID) begin
            state_d = S_EXEC1;
            i_d = '0;
            j_d = '0;
            k_d = '0;
            n_d = '0;
            if (is_mat) begin
               state_d = S_SWEEP;
               vtx_d = 1'b0;
            end else if (I_Opcode == OP_SETVERTEX && prim_q) begin
               state_d = S_SWEEP;
               vtx_d = 1'b1;
            end else if (I_Opcode == OP_BEGINPRIMITIVE) prim_d = 1'b1;
            else if (I_Opcode == OP_ENDPRIMITIVE) prim_d = 1'b0;
            else if (I_Opcode == OP_LOADIDENTITY) ld_d = 1'b1;
            else if (I_Opcode == OP_POPMATRIX) begin
               if (sp_q != '0) sp_d = sp_q - SP_W'(1);
               else unf_d = 1'b1;
            end else if (I_Opcode == OP_PUSHMATRIX) begin
               if (sp_q < SP_MAX) state_d = S_COPY;
               else ovf_d = 1'b1;
            end
         end
         S_EXEC1: begin
            load_id = ld_q;
            state_d = S_IDLE;
         end
         S_SWEEP: begin
            mac_en = 1'b1;
            mac_clr = k_q == 2'd0;
            a_slot = sp_q;
            a_idx = {i_q, k_q};
            b_src = vtx_q;
            b_idx = vtx_q ? {2'b00, k_q} : {k_q, j_q};
            k_d = k_q + 2'd1;
            state_d = k_q == 2'd3 ? S_WB : S_SWEEP;
         end
         S_WB: begin
            wr_en = 1'b1;
            wr_idx = vtx_q ? {2'b00, i_q} : {i_q, j_q};
            // vertex sweeps step rows only; matrix sweeps walk j then i
            if (vtx_q) begin
               i_d = i_q + 2'd1;
               state_d = i_q == 2'd3 ? S_VDONE : S_SWEEP;
            end else begin
               j_d = j_q + 2'd1;
               i_d = j_q == 2'd3 ? i_q + 2'd1 : i_q;
               state_d = (i_q == 2'd3 && j_q == 2'd3) ? S_COMMIT : S_SWEEP;
            end
         end
         S_COMMIT: begin
            commit = 1'b1;
            state_d = S_IDLE;
         end
         S_VDONE: begin
            vtx_valid = 1'b1;
            state_d = S_IDLE;
         end
         S_COPY: begin
            copy_en = 1'b1;
            a_slot = sp_q;
            a_idx = n_q;
            n_d = n_q + 4'd1;
            sp_d = n_q == 4'd15 ? sp_q + SP_W'(1) : sp_q;
            state_d = n_q == 4'd15 ? S_IDLE : S_COPY;
         end
         default: state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
      if (!I_RESET_N) begin
         state_q <= S_IDLE;
         vtx_q <= 1'b0;
         prim_q <= 1'b0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
         ld_q <= 1'b0;
         i_q <= '0;
         j_q <= '0;
         k_q <= '0;
         n_q <= '0;
         sp_q <= '0;
      end else if (I_LOCK) begin
         state_q <= state_d;
         vtx_q <= vtx_d;
         prim_q <= prim_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
         ld_q <= ld_d;
         i_q <= i_d;
         j_q <= j_d;
         k_q <= k_d;
         n_q <= n_d;
         sp_q <= sp_d;
      end
   end
   assign O_CMD_READY = state_q == S_IDLE && I_RESET_N && I_LOCK;
   assign O_MAC_EN = mac_en & I_LOCK;
   assign O_MAC_CLR = mac_clr & I_LOCK;
   assign O_A_SLOT = a_slot;
   assign O_A_IDX = a_idx;
   assign O_B_SRC = b_src;
   assign O_B_IDX = b_idx;
   assign O_WR_EN = wr_en & I_LOCK;
   assign O_WR_IDX = wr_idx;
   assign O_COPY_EN = copy_en & I_LOCK;
   assign O_COMMIT = commit & I_LOCK;
   assign O_LOAD_ID = load_id & I_LOCK;
   assign O_VTX_VALID = vtx_valid & I_LOCK;
   assign O_SP = sp_q;
   assign O_PRIM_ACTIVE = prim_q;
   assign O_OVERFLOW = ovf_q;
   assign O_UNDERFLOW = unf_q;
endmodule

// File: tb/tb_xform_sequencer.sv
// tb_xform_sequencer: directed scenario tasks for xform_sequencer with hand-derived cycle expectations.
module tb_xform_sequencer;
   localparam logic [7:0] OP_BEGINPRIMITIVE = 8'h60;
   localparam logic [7:0] OP_ENDPRIMITIVE = 8'h61;
   localparam logic [7:0] OP_SETVERTEX = 8'h62;
   localparam logic [7:0] OP_ROTATE = 8'h63;
   localparam logic [7:0] OP_TRANSLATE = 8'h64;
   localparam logic [7:0] OP_SCALE = 8'h65;
   localparam logic [7:0] OP_PUSHMATRIX = 8'h66;
   localparam logic [7:0] OP_POPMATRIX = 8'h67;
   localparam logic [7:0] OP_LOADIDENTITY = 8'h68;
   logic clk = 1'b0, rst_n = 1'b0, lock = 1'b1, valid = 1'b0;
   logic [7:0] opc = 8'h00;
   logic ready, mac_en, mac_clr, b_src, wr_en, copy_en, commit, load_id, vtx_valid, prim, ovf, unf;
   logic [1:0] a_slot, sp;
   logic [3:0] a_idx, b_idx, wr_idx;
   logic [27:0] all_out;
   logic [5:0] strobes;
   int checks = 0, passed = 0;
   assign all_out = {ready, mac_en, mac_clr, a_slot, a_idx, b_src, b_idx, wr_en, wr_idx,
                     copy_en, commit, load_id, vtx_valid, sp, prim, ovf, unf};
   assign strobes = {mac_en, wr_en, copy_en, commit, load_id, vtx_valid};
   xform_sequencer dut (
      .I_CLOCK(clk), .I_RESET_N(rst_n), .I_LOCK(lock), .I_CMD_VALID(valid), .I_Opcode(opc),
      .O_CMD_READY(ready), .O_MAC_EN(mac_en), .O_MAC_CLR(mac_clr), .O_A_SLOT(a_slot),
      .O_A_IDX(a_idx), .O_B_SRC(b_src), .O_B_IDX(b_idx), .O_WR_EN(wr_en), .O_WR_IDX(wr_idx),
      .O_COPY_EN(copy_en), .O_COMMIT(commit), .O_LOAD_ID(load_id), .O_VTX_VALID(vtx_valid),
      .O_SP(sp), .O_PRIM_ACTIVE(prim), .O_OVERFLOW(ovf), .O_UNDERFLOW(unf)
   );
   always #5 clk = ~clk;
   task automatic issue(input logic [7:0] op);
      @(negedge clk);
      valid = 1'b1;
      opc = op;
      @(posedge clk);
      #1;
      valid = 1'b0;
   endtask
   task automatic wait_idle(input string name);
      int t;
      t = 0;
      while (ready !== 1'b1 && t < 200) begin
         @(negedge clk);
         #1;
         t++;
      end
      checks++;
      if (ready !== 1'b1) $display("FAIL %s idle_timeout ready=%b want 1", name, ready); else passed++;
   endtask
   task automatic test_reset;
      repeat (2) @(negedge clk);
      checks++;
      if (all_out !== 28'h0) $display("FAIL reset_outputs got %h want 0", all_out); else passed++;
      rst_n = 1'b1;
      #1;
      checks++;
      if (ready !== 1'b1) $display("FAIL reset_ready got %b want 1", ready); else passed++;
      checks++;
      if (sp !== 2'd0) $display("FAIL reset_sp got %0d want 0", sp); else passed++;
      checks++;
      if ({strobes, prim, ovf, unf} !== 9'h0) $display("FAIL reset_idle_strobes got %h want 0", {strobes, prim, ovf, unf}); else passed++;
   endtask
   task automatic test_translate;
      int mac, wr, bad, commit_c, ready_c;
      logic [3:0] exp_wr;
      logic [10:0] c1, c2, c7;
      mac = 0; wr = 0; bad = 0; commit_c = 0; ready_c = 0; exp_wr = 4'd0;
      c1 = '0; c2 = '0; c7 = '0;
      issue(OP_TRANSLATE);
      for (int c = 1; c <= 85; c++) begin
         @(negedge clk);
         if (mac_en) mac++;
         if (wr_en) begin
            if (wr_idx !== exp_wr) bad++;
            exp_wr++;
            wr++;
         end
         if (commit && commit_c == 0) commit_c = c;
         if (ready && ready_c == 0) ready_c = c;
         if (c == 1) c1 = {mac_clr, b_src, a_slot, a_idx, b_idx[2:0]};
         if (c == 2) c2 = {mac_clr, b_src, a_slot, a_idx, b_idx[2:0]};
         if (c == 7) c7 = {mac_clr, b_src, a_slot, a_idx, b_idx[2:0]};
      end
      checks++;
      if (mac !== 64) $display("FAIL mat_mac_count got %0d want 64", mac); else passed++;
      checks++;
      if (wr !== 16 || bad !== 0) $display("FAIL mat_wr got %0d writes %0d out_of_order want 16 0", wr, bad); else passed++;
      checks++;
      if (commit_c !== 81) $display("FAIL mat_commit_cycle got %0d want 81", commit_c); else passed++;
      checks++;
      if (ready_c !== 82) $display("FAIL mat_ready_cycle got %0d want 82", ready_c); else passed++;
      checks++;
      if (c1 !== {1'b1, 1'b0, 2'd0, 4'd0, 3'd0}) $display("FAIL mat_cycle1 got %h want %h", c1, {1'b1, 1'b0, 2'd0, 4'd0, 3'd0}); else passed++;
      checks++;
      if (c2 !== {1'b0, 1'b0, 2'd0, 4'd1, 3'd4}) $display("FAIL mat_cycle2 got %h want %h", c2, {1'b0, 1'b0, 2'd0, 4'd1, 3'd4}); else passed++;
      checks++;
      if (c7 !== {1'b0, 1'b0, 2'd0, 4'd1, 3'd5}) $display("FAIL mat_cycle7 got %h want %h", c7, {1'b0, 1'b0, 2'd0, 4'd1, 3'd5}); else passed++;
   endtask
   task automatic test_vertex;
      int mac, wr, bad, vv_c, ready_c;
      logic [3:0] exp_wr;
      logic [8:0] c1, c7;
      mac = 0; ready_c = 0;
      wait_idle("vtx_pre");
      issue(OP_SETVERTEX);
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         if (mac_en) mac++;
         if (ready && ready_c == 0) ready_c = c;
      end
      checks++;
      if (mac !== 0 || ready_c !== 2) $display("FAIL vtx_noprim got mac=%0d ready_c=%0d want 0 2", mac, ready_c); else passed++;
      issue(OP_BEGINPRIMITIVE);
      @(negedge clk);
      checks++;
      if (prim !== 1'b1) $display("FAIL begin_prim got %b want 1", prim); else passed++;
      wait_idle("vtx_begin");
      mac = 0; wr = 0; bad = 0; vv_c = 0; ready_c = 0; exp_wr = 4'd0; c1 = '0; c7 = '0;
      issue(OP_SETVERTEX);
      for (int c = 1; c <= 24; c++) begin
         @(negedge clk);
         if (mac_en) mac++;
         if (wr_en) begin
            if (wr_idx !== exp_wr) bad++;
            exp_wr++;
            wr++;
         end
         if (vtx_valid && vv_c == 0) vv_c = c;
         if (ready && ready_c == 0) ready_c = c;
         if (c == 1) c1 = {b_src, a_idx, b_idx};
         if (c == 7) c7 = {b_src, a_idx, b_idx};
      end
      checks++;
      if (mac !== 16 || wr !== 4 || bad !== 0) $display("FAIL vtx_counts got mac=%0d wr=%0d bad=%0d want 16 4 0", mac, wr, bad); else passed++;
      checks++;
      if (vv_c !== 21 || ready_c !== 22) $display("FAIL vtx_timing got vv=%0d ready=%0d want 21 22", vv_c, ready_c); else passed++;
      checks++;
      if (c1 !== {1'b1, 4'd0, 4'd0} || c7 !== {1'b1, 4'd5, 4'd1}) $display("FAIL vtx_indices got %h %h want %h %h", c1, c7, {1'b1, 4'd0, 4'd0}, {1'b1, 4'd5, 4'd1}); else passed++;
      issue(OP_ENDPRIMITIVE);
      @(negedge clk);
      checks++;
      if (prim !== 1'b0) $display("FAIL end_prim got %b want 0", prim); else passed++;
      wait_idle("vtx_end");
   endtask
   task automatic test_back_to_back;
      wait_idle("b2b_pre");
      @(negedge clk);
      valid = 1'b1;
      opc = OP_LOADIDENTITY;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({load_id, ready} !== 2'b10) $display("FAIL b2b_cycle1 got load_id,ready=%b want 10", {load_id, ready}); else passed++;
      opc = OP_ROTATE;
      @(negedge clk);
      checks++;
      if ({load_id, ready} !== 2'b01) $display("FAIL b2b_cycle2 got load_id,ready=%b want 01", {load_id, ready}); else passed++;
      @(posedge clk);
      #1;
      valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({mac_en, mac_clr, ready} !== 3'b110) $display("FAIL b2b_rotate_start got %b want 110", {mac_en, mac_clr, ready}); else passed++;
      wait_idle("b2b_post");
   endtask
   task automatic test_lock;
      int mac, stall_bad, commit_c, ready_c;
      logic [4:0] c17;
      mac = 0; stall_bad = 0; commit_c = 0; ready_c = 0; c17 = '0;
      issue(OP_SCALE);
      for (int c = 1; c <= 95; c++) begin
         @(negedge clk);
         lock = !(c >= 10 && c <= 16);
         #1;
         if (!lock && (strobes !== 6'h0 || ready !== 1'b0)) stall_bad++;
         if (mac_en) mac++;
         if (commit && commit_c == 0) commit_c = c;
         if (ready && ready_c == 0) ready_c = c;
         if (c == 17) c17 = {wr_en, wr_idx};
      end
      checks++;
      if (stall_bad !== 0) $display("FAIL lock_stall_strobes got %0d active cycles want 0", stall_bad); else passed++;
      checks++;
      if (c17 !== {1'b1, 4'd1}) $display("FAIL lock_resume got %h want %h", c17, {1'b1, 4'd1}); else passed++;
      checks++;
      if (mac !== 64 || commit_c !== 88 || ready_c !== 89) $display("FAIL lock_timing got mac=%0d commit=%0d ready=%0d want 64 88 89", mac, commit_c, ready_c); else passed++;
   endtask
   task automatic test_push_pop;
      int copies, ready_c;
      logic [11:0] first, last;
      copies = 0; first = '0; last = '0;
      for (int p = 0; p < 4; p++) begin
         wait_idle("push_pre");
         ready_c = 0;
         issue(OP_PUSHMATRIX);
         for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (copy_en) copies++;
            if (ready && ready_c == 0) ready_c = c;
            if (p == 1 && c == 1) first = {copy_en, a_slot, a_idx, sp, ovf, unf, 1'b0};
            if (p == 1 && c == 16) last = {copy_en, a_slot, a_idx, sp, ovf, unf, 1'b0};
         end
         checks++;
         if (ready_c !== (p == 3 ? 2 : 17)) $display("FAIL push%0d_ready got %0d want %0d", p, ready_c, p == 3 ? 2 : 17); else passed++;
         if (p == 2) begin
            checks++;
            if ({sp, ovf} !== {2'd3, 1'b0}) $display("FAIL push3_state got sp=%0d ovf=%b want 3 0", sp, ovf); else passed++;
         end
      end
      checks++;
      if (copies !== 48) $display("FAIL push_copies got %0d want 48", copies); else passed++;
      checks++;
      if ({sp, ovf} !== {2'd3, 1'b1}) $display("FAIL push_overflow got sp=%0d ovf=%b want 3 1", sp, ovf); else passed++;
      checks++;
      if (first !== {1'b1, 2'd1, 4'd0, 2'd1, 2'b00, 1'b0} || last !== {1'b1, 2'd1, 4'd15, 2'd1, 2'b00, 1'b0}) $display("FAIL push_copy_idx got %h %h want %h %h", first, last, {1'b1, 2'd1, 4'd0, 2'd1, 2'b00, 1'b0}, {1'b1, 2'd1, 4'd15, 2'd1, 2'b00, 1'b0}); else passed++;
      for (int p = 0; p < 4; p++) begin
         wait_idle("pop_pre");
         issue(OP_POPMATRIX);
         @(negedge clk);
         if (p == 0) begin
            checks++;
            if (sp !== 2'd2) $display("FAIL pop1_sp got %0d want 2", sp); else passed++;
         end
         if (p == 2) begin
            checks++;
            if ({sp, unf} !== {2'd0, 1'b0}) $display("FAIL pop3_state got sp=%0d unf=%b want 0 0", sp, unf); else passed++;
         end
      end
      checks++;
      if ({sp, unf, ovf} !== {2'd0, 1'b1, 1'b1}) $display("FAIL pop_underflow got sp=%0d unf=%b ovf=%b want 0 1 1", sp, unf, ovf); else passed++;
      wait_idle("pop_post");
   endtask
   task automatic test_reset_mid_sweep;
      int stray;
      stray = 0;
      issue(OP_TRANSLATE);
      repeat (40) @(negedge clk);
      checks++;
      if ({wr_en, wr_idx} !== {1'b1, 4'd7}) $display("FAIL mid_cycle40 got %h want %h", {wr_en, wr_idx}, {1'b1, 4'd7}); else passed++;
      rst_n = 1'b0;
      #1;
      checks++;
      if (all_out !== 28'h0) $display("FAIL mid_reset_outputs got %h want 0", all_out); else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if ({ready, sp, prim, ovf, unf} !== {1'b1, 2'd0, 3'b000}) $display("FAIL mid_reset_release got %b want 100000", {ready, sp, prim, ovf, unf}); else passed++;
      for (int c = 0; c < 90; c++) begin
         @(negedge clk);
         if (strobes !== 6'h0) stray++;
      end
      checks++;
      if (stray !== 0) $display("FAIL mid_reset_no_commit got %0d strobe cycles want 0", stray); else passed++;
   endtask
   initial begin
      test_reset();
      test_translate();
      test_vertex();
      test_back_to_back();
      test_lock();
      test_push_pop();
      test_reset_mid_sweep();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
